// File: rtl/pwm_dc_sequencer.sv
// Duty-cycle table sequencer that masters the PWM register write port.
// The host keeps priority; the sequencer issues one write per step.
module pwm_dc_sequencer #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned AW     = 3,
   parameter int unsigned TICK_W = 24
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cfg_we_i,
   input  logic [7:0]  cfg_addr_i,
   input  logic [31:0] cfg_wdata_i,
   output logic [31:0] cfg_rdata_o,
   input  logic        host_re_i,
   input  logic        host_we_i,
   input  logic [7:0]  host_addr_i,
   input  logic [31:0] host_wdata_i,
   output logic        pwm_re_o,
   output logic        pwm_we_o,
   output logic [7:0]  pwm_addr_o,
   output logic [31:0] pwm_wdata_o,
   output logic        busy_o,
   output logic        irq_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [7:0]  ADDR_DC1 = 8'd12;
   localparam logic [7:0]  ADDR_DC2 = 8'd28;
   localparam logic [AW:0] LEN_MAX  = (AW+1)'(DEPTH);
   localparam logic [31:0] TBL_END  = 32'(64 + 4 * DEPTH);

   logic              en_q, loop_q, chan_q, irq_en_q, irq_q;
   logic [TICK_W-1:0] step_q, cnt_q;
   logic [AW:0]       len_q;
   logic [AW-1:0]     idx_q;
   logic [15:0]       tbl_q [DEPTH];
   state_e            state_q;

   logic          host_act, seq_wr, ctrl_hit, tbl_hit;
   logic          last, step_end;
   logic [AW-1:0] tbl_idx;

   assign host_act = host_re_i | host_we_i;
   assign seq_wr   = en_q & (state_q == ISSUE) & ~host_act;
   assign ctrl_hit = cfg_we_i & (cfg_addr_i == 8'h00);
   assign tbl_hit  = (cfg_addr_i[1:0] == 2'b00) &
                     (cfg_addr_i >= 8'h40) &
                     (32'(cfg_addr_i) < TBL_END);
   assign tbl_idx  = AW'((cfg_addr_i - 8'h40) >> 2);

   // Ends a sequence when idx reaches LEN-1 or LEN was shrunk below idx+1.
   assign last     = ({1'b0, idx_q} + (AW+1)'(1)) >= len_q;
   assign step_end = (seq_wr & (step_q == '0)) |
                     ((state_q == WAIT) & (cnt_q == TICK_W'(1)));

   assign busy_o = (state_q == ISSUE) | (state_q == WAIT);
   assign irq_o  = irq_q;

   // Control, step and length registers written from the config port.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         en_q     <= 1'b0;
         loop_q   <= 1'b0;
         chan_q   <= 1'b0;
         irq_en_q <= 1'b0;
         step_q   <= '0;
         len_q    <= '0;
      end else if (cfg_we_i) begin
         case (cfg_addr_i)
            8'h00: {irq_en_q, chan_q, loop_q, en_q} <= cfg_wdata_i[3:0];
            8'h04: step_q <= cfg_wdata_i[TICK_W-1:0];
            8'h08: len_q  <= (cfg_wdata_i > 32'(DEPTH)) ?
                             LEN_MAX : cfg_wdata_i[AW:0];
            default: ;
         endcase
      end
   end

   // Duty table storage, 16 bits per entry.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
      end else if (cfg_we_i & tbl_hit) begin
         tbl_q[tbl_idx] <= cfg_wdata_i[15:0];
      end
   end

   // Sequencer FSM: index, interval counter and completion interrupt.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         irq_q   <= 1'b0;
      end else begin
         if (ctrl_hit & cfg_wdata_i[4]) irq_q <= 1'b0;
         if (!en_q) begin
            state_q <= IDLE;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (len_q != '0) begin
                     idx_q   <= '0;
                     state_q <= ISSUE;
                  end
               end
               ISSUE: begin
                  if (seq_wr & (step_q != '0)) begin
                     cnt_q   <= step_q;
                     state_q <= WAIT;
                  end
               end
               WAIT: cnt_q <= cnt_q - TICK_W'(1);
               DONE: ;
            endcase
            if (step_end) begin
               if (!last) begin
                  idx_q   <= idx_q + AW'(1);
                  state_q <= ISSUE;
               end else if (loop_q) begin
                  idx_q   <= '0;
                  state_q <= ISSUE;
               end else begin
                  state_q <= DONE;
                  if (irq_en_q) irq_q <= 1'b1;
               end
            end
         end
      end
   end

   // PWM port mux: host first, then a sequencer write, else quiet.
   always_comb begin
      pwm_re_o    = 1'b0;
      pwm_we_o    = 1'b0;
      pwm_addr_o  = '0;
      pwm_wdata_o = '0;
      if (host_act) begin
         pwm_re_o    = host_re_i;
         pwm_we_o    = host_we_i;
         pwm_addr_o  = host_addr_i;
         pwm_wdata_o = host_wdata_i;
      end else if (seq_wr) begin
         pwm_we_o    = 1'b1;
         pwm_addr_o  = chan_q ? ADDR_DC2 : ADDR_DC1;
         pwm_wdata_o = {16'h0, tbl_q[idx_q]};
      end
   end

   // Config read-back decode.
   always_comb begin
      cfg_rdata_o = '0;
      if (tbl_hit) begin
         cfg_rdata_o[15:0] = tbl_q[tbl_idx];
      end else begin
         case (cfg_addr_i)
            8'h00: cfg_rdata_o[3:0] = {irq_en_q, chan_q, loop_q, en_q};
            8'h04: cfg_rdata_o[TICK_W-1:0] = step_q;
            8'h08: cfg_rdata_o[AW:0] = len_q;
            8'h0C: begin
               cfg_rdata_o[AW-1:0] = idx_q;
               cfg_rdata_o[8]      = busy_o;
               cfg_rdata_o[9]      = irq_q;
               cfg_rdata_o[11:10]  = state_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_dc_sequencer.sv
// Directed bench for the PWM duty-cycle sequencer.
// Each task drives one scenario and checks its own results.
module tb_pwm_dc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_we;
   logic [7:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic [31:0] cfg_rdata;
   logic        host_re, host_we;
   logic [7:0]  host_addr;
   logic [31:0] host_wdata;
   logic        pwm_re, pwm_we;
   logic [7:0]  pwm_addr;
   logic [31:0] pwm_wdata;
   logic        busy, irq;

   int tests = 0;
   int fails = 0;

   int          nw;
   int          wcyc [16];
   logic [7:0]  waddr [16];
   logic [31:0] wdat [16];

   pwm_dc_sequencer dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .cfg_we_i     (cfg_we),
      .cfg_addr_i   (cfg_addr),
      .cfg_wdata_i  (cfg_wdata),
      .cfg_rdata_o  (cfg_rdata),
      .host_re_i    (host_re),
      .host_we_i    (host_we),
      .host_addr_i  (host_addr),
      .host_wdata_i (host_wdata),
      .pwm_re_o     (pwm_re),
      .pwm_we_o     (pwm_we),
      .pwm_addr_o   (pwm_addr),
      .pwm_wdata_o  (pwm_wdata),
      .busy_o       (busy),
      .irq_o        (irq)
   );

   always #5 clk = ~clk;

   task automatic cfg_wr(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      @(negedge clk);
      cfg_we    = 1'b0;
      cfg_addr  = 8'h00;
      cfg_wdata = '0;
   endtask

   task automatic cfg_rd(input logic [7:0] a, output logic [31:0] d);
      cfg_addr = a;
      #1;
      d = cfg_rdata;
   endtask

   // Record PWM write cycles over n cycles, cycle 1 = next falling edge.
   task automatic collect(input int n);
      nw = 0;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         if (pwm_we && nw < 16) begin
            wcyc[nw]  = c;
            waddr[nw] = pwm_addr;
            wdat[nw]  = pwm_wdata;
            nw++;
         end
      end
   endtask

   task automatic test_reset;
      logic [31:0] r;
      #2;
      tests++;
      if ({busy, irq, pwm_we, pwm_re} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_outs: got %b want 0000",
                  {busy, irq, pwm_we, pwm_re});
      end
      cfg_rd(8'h0C, r);
      tests++;
      if (r !== 32'h0) begin
         fails++;
         $display("FAIL reset_stat: got %h want 0", r);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_regs;
      logic [31:0] r;
      cfg_wr(8'h40, 32'd100);
      cfg_wr(8'h44, 32'd200);
      cfg_wr(8'h48, 32'h0005_012C);
      cfg_wr(8'h10, 32'hFFFF_FFFF);
      cfg_wr(8'h60, 32'hFFFF_FFFF);
      cfg_rd(8'h48, r);
      tests++;
      if (r !== 32'd300) begin
         fails++;
         $display("FAIL tbl2_rd: got %h want 12c", r);
      end
      cfg_rd(8'h10, r);
      tests++;
      if (r !== 32'h0) begin
         fails++;
         $display("FAIL unmapped_rd: got %h want 0", r);
      end
      cfg_rd(8'h60, r);
      tests++;
      if (r !== 32'h0) begin
         fails++;
         $display("FAIL past_tbl_rd: got %h want 0", r);
      end
      cfg_rd(8'h5C, r);
      tests++;
      if (r !== 32'h0) begin
         fails++;
         $display("FAIL tbl7_rd: got %h want 0", r);
      end
   endtask

   task automatic test_single;
      int          ec [3] = '{1, 6, 11};
      logic [31:0] ed [3] = '{32'd100, 32'd200, 32'd300};
      logic [31:0] r;
      cfg_wr(8'h08, 32'd3);
      cfg_wr(8'h04, 32'd4);
      cfg_wr(8'h00, 32'h1);
      collect(20);
      tests++;
      if (nw !== 3) begin
         fails++;
         $display("FAIL t1_count: got %0d want 3", nw);
      end
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (wcyc[k] !== ec[k] || wdat[k] !== ed[k] || waddr[k] !== 8'd12) begin
            fails++;
            $display("FAIL t1_wr%0d: got c%0d a%0d d%0d want c%0d a12 d%0d",
                     k, wcyc[k], waddr[k], wdat[k], ec[k], ed[k]);
         end
      end
      cfg_rd(8'h0C, r);
      tests++;
      if (busy !== 1'b0 || r[11:10] !== 2'd3) begin
         fails++;
         $display("FAIL t1_done: got busy %b st %0d want busy 0 st 3",
                  busy, r[11:10]);
      end
      cfg_wr(8'h00, 32'h0);
   endtask

   task automatic test_loop;
      int          ec [4] = '{1, 6, 11, 16};
      logic [31:0] ed [4] = '{32'd100, 32'd200, 32'd300, 32'd100};
      logic [31:0] r;
      cfg_wr(8'h00, 32'h7);
      collect(16);
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (nw <= k || wcyc[k] !== ec[k] || wdat[k] !== ed[k] ||
             waddr[k] !== 8'd28) begin
            fails++;
            $display("FAIL t2_wr%0d: got n%0d c%0d a%0d d%0d want c%0d a28 d%0d",
                     k, nw, wcyc[k], waddr[k], wdat[k], ec[k], ed[k]);
         end
      end
      cfg_wr(8'h00, 32'h0);
      @(negedge clk);
      cfg_rd(8'h0C, r);
      tests++;
      if (r[11:10] !== 2'd0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL t2_stop: got st %0d busy %b want st 0 busy 0",
                  r[11:10], busy);
      end
      collect(12);
      tests++;
      if (nw !== 0) begin
         fails++;
         $display("FAIL t2_quiet: got %0d writes want 0", nw);
      end
   endtask

   task automatic test_host;
      int          ec [3] = '{1, 9, 14};
      logic [31:0] ed [3] = '{32'd100, 32'd200, 32'd300};
      int          hok;
      cfg_wr(8'h00, 32'h1);
      nw  = 0;
      hok = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         host_we    = (c >= 6 && c <= 8);
         host_addr  = 8'h10;
         host_wdata = 32'hABCD;
         @(negedge clk);
         if (host_we) begin
            if (pwm_we && pwm_addr == 8'h10 && pwm_wdata == 32'hABCD && !pwm_re)
               hok++;
         end else if (pwm_we && nw < 16) begin
            wcyc[nw]  = c;
            waddr[nw] = pwm_addr;
            wdat[nw]  = pwm_wdata;
            nw++;
         end
      end
      host_we = 1'b0;
      tests++;
      if (hok !== 3) begin
         fails++;
         $display("FAIL t3_host: got %0d host cycles want 3", hok);
      end
      tests++;
      if (nw !== 3) begin
         fails++;
         $display("FAIL t3_count: got %0d want 3", nw);
      end
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (wcyc[k] !== ec[k] || wdat[k] !== ed[k] || waddr[k] !== 8'd12) begin
            fails++;
            $display("FAIL t3_wr%0d: got c%0d d%0d want c%0d d%0d",
                     k, wcyc[k], wdat[k], ec[k], ed[k]);
         end
      end
      cfg_wr(8'h00, 32'h0);
      @(negedge clk);
      host_re   = 1'b1;
      host_addr = 8'h14;
      #1;
      tests++;
      if ({pwm_re, pwm_we, pwm_addr} !== {1'b1, 1'b0, 8'h14}) begin
         fails++;
         $display("FAIL t3_read: got re%b we%b a%h want re1 we0 a14",
                  pwm_re, pwm_we, pwm_addr);
      end
      host_re = 1'b0;
   endtask

   task automatic test_irq;
      logic [31:0] r;
      cfg_wr(8'h08, 32'd1);
      cfg_wr(8'h04, 32'd0);
      cfg_wr(8'h00, 32'h9);
      collect(3);
      tests++;
      if (nw !== 1 || wcyc[0] !== 1 || wdat[0] !== 32'd100) begin
         fails++;
         $display("FAIL t4_write: got n%0d c%0d d%0d want n1 c1 d100",
                  nw, wcyc[0], wdat[0]);
      end
      tests++;
      if (irq !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL t4_irq: got irq %b busy %b want 1 0", irq, busy);
      end
      cfg_wr(8'h00, 32'h19);
      cfg_rd(8'h00, r);
      tests++;
      if (irq !== 1'b0 || r !== 32'h9) begin
         fails++;
         $display("FAIL t4_clr: got irq %b ctrl %h want 0 9", irq, r);
      end
      collect(4);
      cfg_rd(8'h0C, r);
      tests++;
      if (nw !== 0 || r[11:10] !== 2'd3) begin
         fails++;
         $display("FAIL t4_rearm: got n%0d st %0d want n0 st 3", nw, r[11:10]);
      end
      cfg_wr(8'h00, 32'h0);
      cfg_wr(8'h08, 32'd0);
      cfg_wr(8'h00, 32'h1);
      collect(5);
      cfg_rd(8'h0C, r);
      tests++;
      if (nw !== 0 || busy !== 1'b0 || r[11:10] !== 2'd0) begin
         fails++;
         $display("FAIL t4_len0: got n%0d busy %b st %0d want 0 0 0",
                  nw, busy, r[11:10]);
      end
      cfg_wr(8'h00, 32'h0);
   endtask

   task automatic test_back_to_back;
      logic [31:0] ed [3] = '{32'd100, 32'd200, 32'd300};
      logic [31:0] r;
      cfg_wr(8'h08, 32'd15);
      cfg_rd(8'h08, r);
      tests++;
      if (r !== 32'd8) begin
         fails++;
         $display("FAIL t5_len_clamp: got %0d want 8", r);
      end
      cfg_wr(8'h08, 32'd3);
      cfg_wr(8'h04, 32'd0);
      cfg_wr(8'h00, 32'h1);
      collect(6);
      tests++;
      if (nw !== 3) begin
         fails++;
         $display("FAIL t5_count: got %0d want 3", nw);
      end
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (wcyc[k] !== k + 1 || wdat[k] !== ed[k]) begin
            fails++;
            $display("FAIL t5_wr%0d: got c%0d d%0d want c%0d d%0d",
                     k, wcyc[k], wdat[k], k + 1, ed[k]);
         end
      end
      tests++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL t5_noirq: got %b want 0", irq);
      end
      cfg_wr(8'h00, 32'h0);
   endtask

   task automatic test_async_reset;
      logic [31:0] r;
      cfg_wr(8'h04, 32'd4);
      cfg_wr(8'h00, 32'h9);
      repeat (3) @(negedge clk);
      cfg_rd(8'h0C, r);
      tests++;
      if (busy !== 1'b1 || r[11:10] !== 2'd2) begin
         fails++;
         $display("FAIL t6_wait: got busy %b st %0d want 1 2", busy, r[11:10]);
      end
      #1;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({busy, irq, pwm_we} !== 3'b000) begin
         fails++;
         $display("FAIL t6_outs: got %b want 000", {busy, irq, pwm_we});
      end
      for (int k = 0; k < 4; k++) begin
         logic [7:0] a;
         a = (k == 3) ? 8'h40 : 8'(4 * k);
         cfg_rd(a, r);
         tests++;
         if (r !== 32'h0) begin
            fails++;
            $display("FAIL t6_reg%h: got %h want 0", a, r);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      cfg_we     = 1'b0;
      cfg_addr   = '0;
      cfg_wdata  = '0;
      host_re    = 1'b0;
      host_we    = 1'b0;
      host_addr  = '0;
      host_wdata = '0;
      test_reset();
      test_regs();
      test_single();
      test_loop();
      test_host();
      test_irq();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got stuck want done");
      $fatal(1);
   end

endmodule
